voice_scheduler: RTL
====================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have a single clock `clk` and one synchronous, active-high reset `reset`.
REQ-002 Ports (name, direction, width, meaning), listed one per line below.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- play  in  1  playback enable; low aborts pending wait
- new_note  in  1  one-cycle pulse from song sequencer; note/duration/advance valid this cycle
- note  in  6  note code; 0 = rest
- duration  in  6  length in beats
- advance  in  1  1 = hold sequencer for duration; 0 = chord member, release immediately
- beat  in  1  one-cycle beat tick
- voice_done  in  3  per-voice one-cycle pulse, voice finished its note
- voice_load  out  3  one-hot, one-cycle load strobe to a voice
- voice_note  out  6  note for loaded voice
- voice_duration  out  6  duration for loaded voice
- voice_busy  out  3  per-voice occupancy flags
- note_done  out  1  one-cycle pulse to song sequencer
- stolen  out  1  one-cycle pulse, allocation evicted a busy voice

Function
REQ-003 FSM states SHALL be IDLE, ALLOC, HOLD, ACK; encoded in a registered state vector.
REQ-004 IDLE: on new_note && play, latch note/duration/advance, go ALLOC; new_note while play=0 SHALL be ignored.
REQ-005 ALLOC (one cycle): if note!=0 and duration!=0, pulse exactly one voice_load bit; voice_note/voice_duration SHALL equal latched values that cycle, else 0.
REQ-006 Voice selection: lowest-index voice with voice_busy=0; if all busy, voice at steal pointer, stolen=1 that cycle, steal pointer advances 0->1->2->0.
REQ-007 Steal pointer SHALL change only on a steal.
REQ-008 Rest (note=0) or duration=0: no voice_load, no busy change, stolen=0.
REQ-009 ALLOC exit: advance=0 or duration=0 -> ACK; else -> HOLD with beat counter cleared.
REQ-010 HOLD: count beat pulses (6-bit); beat in the ALLOC cycle SHALL NOT count; when count reaches latched duration -> ACK.
REQ-011 ACK (one cycle): note_done=1, then IDLE.
REQ-012 Latency: new_note at cycle N -> voice_load at N+1 -> note_done at N+2 for advance=0.
REQ-013 Latency: for advance=1, note_done one cycle after the cycle registering the duration-th beat.
REQ-014 play=0 in ALLOC or HOLD: go IDLE next cycle, no note_done, no voice_load in that cycle, beat counter cleared.
REQ-015 voice_busy[i] set on voice_load[i], cleared on voice_done[i]; simultaneous load and done on same voice -> busy stays 1.
REQ-016 voice_busy SHALL be unaffected by play; voices run out naturally.
REQ-017 new_note outside IDLE SHALL be ignored (no latch, no state change).
REQ-018 voice_load, note_done, stolen SHALL never be asserted for more than one consecutive cycle.

Reset
REQ-019 reset SHALL force state IDLE, voice_busy=000, steal pointer=0, beat counter=0, latched fields=0.
REQ-020 During and the cycle after reset, voice_load=000, note_done=0, stolen=0, voice_note=0, voice_duration=0.
REQ-021 reset SHALL take priority over all inputs, including mid-HOLD.

Verification
REQ-022 Chord: three new_note pulses, advance=0, notes 10/14/17, all voices free -> voice_load 001,010,100 each at N+1, note_done each at N+2, voice_busy=111.
REQ-023 Steal: voice_busy=111, pointer 0, note 20 advance=0 -> voice_load=001, stolen=1; next steal loads 010.
REQ-024 Hold: note 5, duration 3, advance=1, beats every 4 cycles -> note_done exactly one cycle after 3rd counted beat; beat coincident with load not counted.
REQ-025 Rest: note=0 duration=2 advance=1 -> no voice_load, note_done after 2 beats; note=9 duration=0 -> no load, note_done at N+2.
REQ-026 Abort/release: play dropped mid-HOLD -> IDLE, no note_done; voice_done[1] coincident with voice_load[1] -> voice_busy[1]=1; reset mid-HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
//
// Sits between a song sequencer and a bank of three synthesiser voices. Each
// note event from the sequencer is handed to one voice: the lowest-numbered
// idle voice if there is one, otherwise a busy voice is evicted in round-robin
// order. A note either releases the sequencer immediately (chord member) or
// holds it for a number of beat ticks before acknowledging.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   play            playback enable; dropping it abandons the current note
//   new_note        one-cycle note event; note/duration/advance valid with it
//   note[5:0]       note code, 0 means rest
//   duration[5:0]   note length in beats
//   advance         1: hold the sequencer for 'duration' beats, 0: release now
//   beat            one-cycle beat tick
//   voice_done[2:0] per-voice one-cycle "note finished" pulse
//   voice_load[2:0] one-hot, one-cycle load strobe to the selected voice
//   voice_note[5:0] note code for the voice being loaded (0 otherwise)
//   voice_duration[5:0] duration for the voice being loaded (0 otherwise)
//   voice_busy[2:0] per-voice occupancy flags
//   note_done       one-cycle acknowledge back to the sequencer
//   stolen          one-cycle pulse when the load evicted a busy voice
//
// Timing
//   new_note in cycle N -> voice_load in N+1 -> note_done in N+2 (advance=0).
//   With advance=1 note_done follows the cycle that registers the
//   duration-th beat of the HOLD phase.
// -----------------------------------------------------------------------------
module voice_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       new_note,
  input  logic [5:0] note,
  input  logic [5:0] duration,
  input  logic       advance,
  input  logic       beat,
  input  logic [2:0] voice_done,
  output logic [2:0] voice_load,
  output logic [5:0] voice_note,
  output logic [5:0] voice_duration,
  output logic [2:0] voice_busy,
  output logic       note_done,
  output logic       stolen
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    HOLD  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_d;

  logic [5:0] note_q;       // note code captured with new_note
  logic [5:0] dur_q;        // duration captured with new_note
  logic       adv_q;        // advance flag captured with new_note
  logic [5:0] beat_cnt;     // beats counted in HOLD
  logic [1:0] steal_ptr;    // next voice to evict when all are busy (0..2)

  // Control strobes produced by the next-state logic
  logic       latch_en;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       steal_adv;

  // ---------------------------------------------------------------------------
  // Voice selection
  // ---------------------------------------------------------------------------
  logic       playable;     // latched event actually sounds (not a rest, len>0)
  logic       all_busy;
  logic [2:0] free_onehot;  // lowest-index idle voice
  logic [2:0] steal_onehot; // voice at the steal pointer
  logic [2:0] sel_onehot;
  logic       last_beat;    // this beat completes the held duration

  assign playable = (note_q != 6'd0) && (dur_q != 6'd0);
  assign all_busy = &voice_busy;

  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    free_onehot = 3'b000;
    if (!voice_busy[0]) begin
      free_onehot = 3'b001;
    end else if (!voice_busy[1]) begin
      free_onehot = 3'b010;
    end else if (!voice_busy[2]) begin
      free_onehot = 3'b100;
    end
  end

  always_comb begin
    steal_onehot = 3'b001;
    case (steal_ptr)
      2'd1:    steal_onehot = 3'b010;
      2'd2:    steal_onehot = 3'b100;
      default: steal_onehot = 3'b001;
    endcase
  end

  assign sel_onehot = all_busy ? steal_onehot : free_onehot;

  // The beat being registered this cycle is the final one when the count
  // after it equals the latched duration.
  assign last_beat = (6'(beat_cnt + 6'd1) == dur_q);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state;
    voice_load     = 3'b000;
    voice_note     = 6'd0;
    voice_duration = 6'd0;
    note_done      = 1'b0;
    stolen         = 1'b0;
    latch_en       = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    steal_adv      = 1'b0;

    case (state)
      IDLE: begin
        // Events arriving while playback is stopped are dropped.
        if (new_note && play) begin
          latch_en = 1'b1;
          state_d  = ALLOC;
        end
      end

      ALLOC: begin
        if (!play) begin
          // Abandon the event before anything reaches a voice.
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          if (playable) begin
            voice_load     = sel_onehot;
            voice_note     = note_q;
            voice_duration = dur_q;
            if (all_busy) begin
              stolen    = 1'b1;
              steal_adv = 1'b1;
            end
          end
          // A zero-length event has nothing to wait for, even if it asks to
          // hold the sequencer. The beat counter starts clean so a beat in
          // this cycle is never counted.
          if (!adv_q || (dur_q == 6'd0)) begin
            state_d = ACK;
          end else begin
            state_d = HOLD;
            cnt_clr = 1'b1;
          end
        end
      end

      HOLD: begin
        if (!play) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (beat) begin
          cnt_inc = 1'b1;
          if (last_beat) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        note_done = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset overrides every strobe in the cycle it is asserted, so nothing
    // leaks out of a state that is about to be discarded.
    if (reset) begin
      voice_load     = 3'b000;
      voice_note     = 6'd0;
      voice_duration = 6'd0;
      note_done      = 1'b0;
      stolen         = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the latched note fields are ordinary control registers, not a
      // memory array, so clearing them on reset is cheap and keeps voice_note
      // and voice_duration deterministic from the first cycle.
      state      <= IDLE;
      note_q     <= 6'd0;
      dur_q      <= 6'd0;
      adv_q      <= 1'b0;
      beat_cnt   <= 6'd0;
      steal_ptr  <= 2'd0;
      voice_busy <= 3'b000;
    end else begin
      state <= state_d;

      if (latch_en) begin
        note_q <= note;
        dur_q  <= duration;
        adv_q  <= advance;
      end

      if (cnt_clr) begin
        beat_cnt <= 6'd0;
      end else if (cnt_inc) begin
        beat_cnt <= 6'(beat_cnt + 6'd1);
      end

      // Round-robin eviction order 0 -> 1 -> 2 -> 0; only a steal moves it.
      if (steal_adv) begin
        steal_ptr <= (steal_ptr == 2'd2) ? 2'd0 : 2'(steal_ptr + 2'd1);
      end

      // A load in the same cycle as a done on that voice wins: the voice has
      // just been given a new note and is occupied again. Playback state has
      // no effect here; voices finish on their own.
      voice_busy <= (voice_busy & ~voice_done) | voice_load;
    end
  end

endmodule
